// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared types and helpers for the serial pattern detector.
//               - state_t           : detector FSM state (2-bit encoding)
//               - c_default_pattern : default 4-bit target pattern
//               - sat_inc()         : saturating increment helper
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    // FILL: history not yet full, SCAN: full and last compare missed,
    // HIT: last compare matched.
    typedef enum logic [1:0] {
        FILL = 2'b00,
        SCAN = 2'b01,
        HIT  = 2'b10
    } state_t;

    localparam logic [3:0] c_default_pattern = 4'b1011;

    // Increment that sticks at max_value instead of wrapping. Operates on
    // 32-bit values, so callers with narrower counters cast in and out.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        if (value >= max_value) begin
            return value;
        end
        return value + 32'd1;
    endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_reg
// Description : LEN-bit serial history register with a fill counter.
//               New bits enter at the LSB, so the oldest bit sits at the MSB.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous active-high reset
//               en    - shift enable
//               clear - synchronous clear of history and fill (beats en)
//               din   - serial input bit
//               hist  - current history
//               fill  - number of valid bits held, saturates at LEN
//               full  - fill == LEN
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_reg #(
    parameter int LEN    = 4,
    parameter int FILL_W = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clear,
    input  logic              din,
    output logic [LEN-1:0]    hist,
    output logic [FILL_W-1:0] fill,
    output logic              full
);

    localparam logic [FILL_W-1:0] c_len = FILL_W'(LEN);

    logic [LEN-1:0]    r_hist;
    logic [FILL_W-1:0] r_fill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (en) begin
            r_hist <= {r_hist[LEN-2:0], din};
            if (r_fill != c_len) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    assign hist = r_hist;
    assign fill = r_fill;
    assign full = (r_fill == c_len);

endmodule : seq_shift_reg
`default_nettype wire

// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_detector
// Description : Detects a fixed LEN-bit pattern (MSB first) in a serial
//               stream, with a one-cycle registered match pulse and a
//               saturating match counter. Overlapping or non-overlapping
//               detection is selected by OVERLAP.
// Ports       : clk         - clock, rising edge
//               reset       - asynchronous active-high reset
//               din         - serial data bit
//               en          - sample enable
//               clear       - synchronous clear (beats en)
//               match       - one-cycle pulse after the final pattern bit
//               match_count - matches since reset/clear, saturating
//               busy        - history holds at least one bit
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = c_default_pattern,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8      // up to 32 (sat_inc width)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             en,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy
);

    localparam int                c_fill_w   = $clog2(LEN + 1);
    localparam logic [c_fill_w-1:0] c_len_m1 = c_fill_w'(LEN - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

    logic [LEN-1:0]      w_hist;
    logic [c_fill_w-1:0] w_fill;
    logic                w_full;
    logic [LEN-1:0]      w_hist_nxt;
    logic                w_full_nxt;
    logic                w_sample;
    logic                w_hit;
    logic                w_flush;
    logic                w_sr_clear;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_match;
    logic                w_match_nxt;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;

    seq_shift_reg #(
        .LEN    (LEN),
        .FILL_W (c_fill_w)
    ) u_shift (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clear (w_sr_clear),
        .din   (din),
        .hist  (w_hist),
        .fill  (w_fill),
        .full  (w_full)
    );

    // The compare looks at the history as it will be after this edge, so the
    // match pulse is registered on the same edge that samples the last bit.
    assign w_hist_nxt = {w_hist[LEN-2:0], din};
    assign w_full_nxt = w_full || (w_fill == c_len_m1);
    assign w_sample   = en && !clear;
    assign w_hit      = w_sample && w_full_nxt && (w_hist_nxt == PATTERN);

    // Without overlap, a hit wipes the history in the same edge so the next
    // match needs LEN fresh bits.
    generate
        if (OVERLAP) begin : g_overlap
            assign w_flush = 1'b0;
        end else begin : g_no_overlap
            assign w_flush = w_hit;
        end
    endgenerate

    assign w_sr_clear = clear || w_flush;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = FILL;
        end else if (en) begin
            if (w_hit) begin
                w_state_nxt = HIT;
            end else if (w_full_nxt) begin
                w_state_nxt = SCAN;
            end else begin
                w_state_nxt = FILL;
            end
        end
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        w_match_nxt = w_hit;
        w_count_nxt = r_count;
        if (clear) begin
            w_count_nxt = '0;
        end else if (w_hit) begin
            w_count_nxt = CNT_W'(sat_inc(32'(r_count), 32'(c_cnt_max)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_match <= 1'b0;
            r_count <= '0;
        end else begin
            r_match <= w_match_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign match       = r_match;
    assign match_count = r_count;
    assign busy        = (w_fill != '0);

endmodule : seq_pattern_detector
`default_nettype wire
